// File: rtl/exu_mul_issue_ctl_pkg.sv
// Shared SweRV type package for the multiplier issue path.
//   mul_pkt_t : decode-to-multiplier control packet
//   mul_op_e  : dec_mul_op encoding (MUL / MULH / MULHSU / MULHU)
package swerv_types;

    typedef struct packed {
        logic valid;
        logic rs1_sign;
        logic rs2_sign;
        logic low;
        logic load_mul_rs1_bypass_e1;
        logic load_mul_rs2_bypass_e1;
    } mul_pkt_t;

    typedef enum logic [1:0] {
        MUL    = 2'd0,
        MULH   = 2'd1,
        MULHSU = 2'd2,
        MULHU  = 2'd3
    } mul_op_e;

endpackage

// File: rtl/exu_mul_issue_ctl_if.sv
// Bundle of decode/LSU inputs and multiplier-control outputs for
// exu_mul_issue_ctl.
//   master : decode/LSU side (drives decode and load info, receives mp,
//            stall, bypass and writeback signals)
//   slave  : the issue controller
interface exu_mul_issue_ctl_if #(parameter int REG_AW = 5);

    logic                   freeze;
    logic                   flush;
    logic                   dec_valid;
    logic                   dec_mul;
    logic [1:0]             dec_mul_op;
    logic                   dec_rs1_en;
    logic                   dec_rs2_en;
    logic [REG_AW-1:0]      dec_rs1_addr;
    logic [REG_AW-1:0]      dec_rs2_addr;
    logic [REG_AW-1:0]      dec_rd_addr;
    logic                   lsu_ld_valid_dc2;
    logic [REG_AW-1:0]      lsu_ld_rd_dc2;

    swerv_types::mul_pkt_t  mp;
    logic                   mul_stall;
    logic                   mul_wen_e3;
    logic [REG_AW-1:0]      mul_rd_e3;
    logic                   mul_byp_rs1_e3;
    logic                   mul_byp_rs2_e3;
    logic                   mul_busy;

    modport master (
        output freeze, flush, dec_valid, dec_mul, dec_mul_op,
               dec_rs1_en, dec_rs2_en, dec_rs1_addr, dec_rs2_addr, dec_rd_addr,
               lsu_ld_valid_dc2, lsu_ld_rd_dc2,
        input  mp, mul_stall, mul_wen_e3, mul_rd_e3,
               mul_byp_rs1_e3, mul_byp_rs2_e3, mul_busy
    );

    modport slave (
        input  freeze, flush, dec_valid, dec_mul, dec_mul_op,
               dec_rs1_en, dec_rs2_en, dec_rs1_addr, dec_rs2_addr, dec_rd_addr,
               lsu_ld_valid_dc2, lsu_ld_rd_dc2,
        output mp, mul_stall, mul_wen_e3, mul_rd_e3,
               mul_byp_rs1_e3, mul_byp_rs2_e3, mul_busy
    );

endinterface

// File: rtl/exu_mul_shadow_stage.sv
// One shadow-pipeline stage: {v, rd} of an in-flight multiply.
//   clk, rst_l         : clock, async active-low reset
//   clear              : drop the entry (v <= 0); beats hold and load
//   hold               : keep current contents
//   load               : capture v_in/rd_in
//   rs1_addr, rs2_addr : decode sources to compare against rd
//   v, rd              : stage contents
//   rs1_match, rs2_match : valid entry whose rd equals the source
module exu_mul_shadow_stage #(
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              clear,
    input  logic              hold,
    input  logic              load,
    input  logic              v_in,
    input  logic [REG_AW-1:0] rd_in,
    input  logic [REG_AW-1:0] rs1_addr,
    input  logic [REG_AW-1:0] rs2_addr,
    output logic              v,
    output logic [REG_AW-1:0] rd,
    output logic              rs1_match,
    output logic              rs2_match
);

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            v  <= 1'b0;
            rd <= '0;
        end else if (clear) begin
            v  <= 1'b0;
        end else if (!hold && load) begin
            v  <= v_in;
            rd <= rd_in;
        end
    end

    assign rs1_match = v & (rs1_addr == rd);
    assign rs2_match = v & (rs2_addr == rd);

endmodule

// File: rtl/exu_mul_issue_ctl.sv
// Decode-side issue controller for the three-stage multiplier.
//   clk, rst_l : core clock, async active-low reset
//   bus        : exu_mul_issue_ctl_if slave port carrying freeze/flush,
//                decode fields and DC2 load info in; mul_pkt_t, decode
//                stall, E3 bypass flags, E3 writeback and busy out.
// Tracks in-flight multiply destinations in E1/E2/E3, stalls decode on
// RAW hazards against E1/E2 and flags E3 matches for result bypass.
module exu_mul_issue_ctl
    import swerv_types::*;
#(
    parameter int REG_AW = 5
) (
    input  logic               clk,
    input  logic               rst_l,
    exu_mul_issue_ctl_if.slave bus
);

    logic [2:0]        st_v;
    logic [REG_AW-1:0] st_rd [3];
    logic [2:0]        m1;
    logic [2:0]        m2;
    logic              rs1_chk;
    logic              rs2_chk;
    logic              stall;
    logic              issue;

    assign rs1_chk = bus.dec_rs1_en & (bus.dec_rs1_addr != '0);
    assign rs2_chk = bus.dec_rs2_en & (bus.dec_rs2_addr != '0);

    // E1/E2 matches cannot be satisfied yet; E3 is served by bypass.
    assign stall = bus.dec_valid &
                   ((rs1_chk & (m1[0] | m1[1])) | (rs2_chk & (m2[0] | m2[1])));
    assign issue = bus.dec_valid & bus.dec_mul & ~stall & ~bus.freeze & ~bus.flush;

    always_comb begin
        bus.mp = '0;
        if (issue) begin
            bus.mp.valid    = 1'b1;
            bus.mp.rs1_sign = (bus.dec_mul_op == MULH) | (bus.dec_mul_op == MULHSU);
            bus.mp.rs2_sign = (bus.dec_mul_op == MULH);
            bus.mp.low      = (bus.dec_mul_op == MUL);
            bus.mp.load_mul_rs1_bypass_e1 = rs1_chk & bus.lsu_ld_valid_dc2 &
                                            (bus.dec_rs1_addr == bus.lsu_ld_rd_dc2);
            bus.mp.load_mul_rs2_bypass_e1 = rs2_chk & bus.lsu_ld_valid_dc2 &
                                            (bus.dec_rs2_addr == bus.lsu_ld_rd_dc2);
        end
    end

    // Writes to x0 are never tracked, so they cannot stall or write back.
    exu_mul_shadow_stage #(.REG_AW(REG_AW)) u_e1 (
        .clk(clk), .rst_l(rst_l),
        .clear(bus.flush), .hold(bus.freeze), .load(1'b1),
        .v_in(issue & (bus.dec_rd_addr != '0)), .rd_in(bus.dec_rd_addr),
        .rs1_addr(bus.dec_rs1_addr), .rs2_addr(bus.dec_rs2_addr),
        .v(st_v[0]), .rd(st_rd[0]), .rs1_match(m1[0]), .rs2_match(m2[0])
    );

    exu_mul_shadow_stage #(.REG_AW(REG_AW)) u_e2 (
        .clk(clk), .rst_l(rst_l),
        .clear(bus.flush), .hold(bus.freeze), .load(1'b1),
        .v_in(st_v[0]), .rd_in(st_rd[0]),
        .rs1_addr(bus.dec_rs1_addr), .rs2_addr(bus.dec_rs2_addr),
        .v(st_v[1]), .rd(st_rd[1]), .rs1_match(m1[1]), .rs2_match(m2[1])
    );

    // E3 is never cleared itself: a flush kills the E2 entry on its way in,
    // and under freeze+flush E3 simply holds.
    exu_mul_shadow_stage #(.REG_AW(REG_AW)) u_e3 (
        .clk(clk), .rst_l(rst_l),
        .clear(1'b0), .hold(bus.freeze), .load(1'b1),
        .v_in(st_v[1] & ~bus.flush), .rd_in(st_rd[1]),
        .rs1_addr(bus.dec_rs1_addr), .rs2_addr(bus.dec_rs2_addr),
        .v(st_v[2]), .rd(st_rd[2]), .rs1_match(m1[2]), .rs2_match(m2[2])
    );

    assign bus.mul_stall      = stall;
    assign bus.mul_byp_rs1_e3 = bus.dec_valid & rs1_chk & m1[2];
    assign bus.mul_byp_rs2_e3 = bus.dec_valid & rs2_chk & m2[2];
    assign bus.mul_wen_e3     = st_v[2] & ~bus.freeze;
    assign bus.mul_rd_e3      = st_rd[2];
    assign bus.mul_busy       = |st_v;

endmodule

// File: tb/tb_exu_mul_issue_ctl.sv
// Scoreboard bench for exu_mul_issue_ctl. The driver applies one stimulus
// per cycle at the falling edge, derives the expected outputs from a list
// of in-flight multiplies (destination + age), and queues them; the
// monitor pops and compares shortly after each falling edge.
module tb_exu_mul_issue_ctl;
    import swerv_types::*;

    localparam int AW = 5;

    typedef struct {
        logic          rst_l, freeze, flush, dec_valid, dec_mul;
        logic [1:0]    op;
        logic          rs1_en, rs2_en;
        logic [AW-1:0] rs1, rs2, rd;
        logic          ld_v;
        logic [AW-1:0] ld_rd;
    } stim_t;

    typedef struct {
        mul_pkt_t      mp;
        logic          stall, wen, byp1, byp2, busy, chk_rd;
        logic [AW-1:0] rd;
    } exp_t;

    typedef struct {
        logic [AW-1:0] rd;
        int unsigned   age;   // 1 = E1, 2 = E2, 3 = E3
    } infl_t;

    logic clk = 1'b0;
    logic rst_l;
    always #5 clk = ~clk;

    exu_mul_issue_ctl_if #(.REG_AW(AW)) bus ();
    exu_mul_issue_ctl #(.REG_AW(AW)) dut (.clk(clk), .rst_l(rst_l), .bus(bus));

    exp_t  exp_q[$];
    infl_t infl[$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{rst_l: 1'b1, freeze: 1'b0, flush: 1'b0, dec_valid: 1'b0, dec_mul: 1'b0,
              op: 2'd0, rs1_en: 1'b0, rs2_en: 1'b0, rs1: '0, rs2: '0, rd: '0,
              ld_v: 1'b0, ld_rd: '0};
        return s;
    endfunction

    function automatic stim_t mul(input logic [1:0] op, input logic [AW-1:0] rd,
                                  input logic [AW-1:0] rs1, input logic [AW-1:0] rs2);
        stim_t s;
        s = idle();
        s.dec_valid = 1'b1; s.dec_mul = 1'b1; s.op = op; s.rd = rd;
        s.rs1_en = 1'b1; s.rs2_en = 1'b1; s.rs1 = rs1; s.rs2 = rs2;
        return s;
    endfunction

    task automatic step(input stim_t s);
        exp_t  e;
        infl_t nq[$];
        logic  h1, h2, b1, b2, has3, ok1, ok2, iss;
        logic [AW-1:0] rd3;
        @(negedge clk);
        rst_l = s.rst_l;
        bus.freeze = s.freeze; bus.flush = s.flush;
        bus.dec_valid = s.dec_valid; bus.dec_mul = s.dec_mul; bus.dec_mul_op = s.op;
        bus.dec_rs1_en = s.rs1_en; bus.dec_rs2_en = s.rs2_en;
        bus.dec_rs1_addr = s.rs1; bus.dec_rs2_addr = s.rs2; bus.dec_rd_addr = s.rd;
        bus.lsu_ld_valid_dc2 = s.ld_v; bus.lsu_ld_rd_dc2 = s.ld_rd;
        if (!s.rst_l) infl.delete();

        h1 = 0; h2 = 0; b1 = 0; b2 = 0; has3 = 0; rd3 = '0;
        foreach (infl[i]) begin
            if (infl[i].age < 3) begin
                if (infl[i].rd == s.rs1) h1 = 1;
                if (infl[i].rd == s.rs2) h2 = 1;
            end else begin
                has3 = 1; rd3 = infl[i].rd;
                if (infl[i].rd == s.rs1) b1 = 1;
                if (infl[i].rd == s.rs2) b2 = 1;
            end
        end
        ok1 = s.rs1_en && s.rs1 != 0;
        ok2 = s.rs2_en && s.rs2 != 0;
        e.stall = s.dec_valid && ((ok1 && h1) || (ok2 && h2));
        e.byp1  = s.dec_valid && ok1 && b1;
        e.byp2  = s.dec_valid && ok2 && b2;
        iss = s.dec_valid && s.dec_mul && !e.stall && !s.freeze && !s.flush;
        e.mp = '0;
        if (iss) begin
            e.mp.valid    = 1'b1;
            e.mp.rs1_sign = (s.op == 2'd1) || (s.op == 2'd2);
            e.mp.rs2_sign = (s.op == 2'd1);
            e.mp.low      = (s.op == 2'd0);
            e.mp.load_mul_rs1_bypass_e1 = ok1 && s.ld_v && s.rs1 == s.ld_rd;
            e.mp.load_mul_rs2_bypass_e1 = ok2 && s.ld_v && s.rs2 == s.ld_rd;
        end
        e.wen    = has3 && !s.freeze;
        e.busy   = infl.size() != 0;
        e.chk_rd = has3 || !s.rst_l;
        e.rd     = has3 ? rd3 : '0;
        exp_q.push_back(e);

        if (s.rst_l) begin
            foreach (infl[i]) begin
                if (s.flush && infl[i].age < 3) begin
                    // killed
                end else if (s.freeze) begin
                    nq.push_back(infl[i]);
                end else if (infl[i].age < 3) begin
                    nq.push_back('{rd: infl[i].rd, age: infl[i].age + 1});
                end
            end
            if (iss && s.rd != 0) nq.push_back('{rd: s.rd, age: 1});
            infl = nq;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("mp",        32'(bus.mp),             32'(e.mp));
                chk("mul_stall", 32'(bus.mul_stall),      32'(e.stall));
                chk("byp_rs1",   32'(bus.mul_byp_rs1_e3), 32'(e.byp1));
                chk("byp_rs2",   32'(bus.mul_byp_rs2_e3), 32'(e.byp2));
                chk("wen_e3",    32'(bus.mul_wen_e3),     32'(e.wen));
                chk("mul_busy",  32'(bus.mul_busy),       32'(e.busy));
                if (e.chk_rd) chk("rd_e3", 32'(bus.mul_rd_e3), 32'(e.rd));
            end
        end
    end

    initial begin : driver
        stim_t s;
        rst_l = 1'b0;
        bus.freeze = 0; bus.flush = 0; bus.dec_valid = 0; bus.dec_mul = 0;
        bus.dec_mul_op = '0; bus.dec_rs1_en = 0; bus.dec_rs2_en = 0;
        bus.dec_rs1_addr = '0; bus.dec_rs2_addr = '0; bus.dec_rd_addr = '0;
        bus.lsu_ld_valid_dc2 = 0; bus.lsu_ld_rd_dc2 = '0;

        s = idle(); s.rst_l = 1'b0;
        step(s); step(s);
        step(idle());

        // decode fields: MULHSU rd=5, writeback three cycles later
        step(mul(2'd2, 5'd5, 5'd1, 5'd2));
        repeat (4) step(idle());

        // RAW: MUL rd=7 then ADD rs1=7 held in decode
        step(mul(2'd0, 5'd7, 5'd1, 5'd2));
        s = idle(); s.dec_valid = 1; s.rs1_en = 1; s.rs1 = 5'd7; s.rs2_en = 1; s.rs2 = 5'd3;
        repeat (3) step(s);
        step(idle());

        // load bypass on rs2, then x0 load must not bypass
        s = mul(2'd3, 5'd10, 5'd8, 5'd9); s.ld_v = 1; s.ld_rd = 5'd9;
        step(s);
        s = mul(2'd1, 5'd11, 5'd8, 5'd0); s.ld_v = 1; s.ld_rd = 5'd0;
        step(s);
        repeat (4) step(idle());

        // x0 destination
        step(mul(2'd0, 5'd0, 5'd1, 5'd2));
        s = idle(); s.dec_valid = 1; s.rs1_en = 1; s.rs1 = 5'd0;
        step(s); step(s); step(s);
        step(idle());

        // flush with rd=3 in E1, rd=2 in E2, rd=1 in E3
        step(mul(2'd0, 5'd1, 5'd0, 5'd0));
        step(mul(2'd0, 5'd2, 5'd0, 5'd0));
        step(mul(2'd0, 5'd3, 5'd0, 5'd0));
        s = idle(); s.flush = 1; step(s);
        repeat (4) step(idle());

        // freeze two cycles with rd=4 in E2
        step(mul(2'd0, 5'd4, 5'd0, 5'd0));
        step(idle());
        s = idle(); s.freeze = 1; step(s); step(s);
        repeat (4) step(idle());

        // reset mid-pipeline
        step(mul(2'd0, 5'd6, 5'd0, 5'd0));
        step(mul(2'd1, 5'd12, 5'd0, 5'd0));
        s = idle(); s.rst_l = 1'b0; step(s);
        repeat (4) step(idle());

        // randomized traffic, small register window to force hazards
        for (int i = 0; i < 3000; i++) begin
            s = idle();
            s.rst_l     = ($urandom_range(0, 199) != 0);
            s.freeze    = ($urandom_range(0, 9) == 0);
            s.flush     = ($urandom_range(0, 19) == 0);
            s.dec_valid = s.rst_l && ($urandom_range(0, 9) < 8);
            s.dec_mul   = ($urandom_range(0, 1) == 1);
            s.op        = 2'($urandom_range(0, 3));
            s.rs1_en    = ($urandom_range(0, 3) != 0);
            s.rs2_en    = ($urandom_range(0, 3) != 0);
            s.rs1       = AW'($urandom_range(0, 7));
            s.rs2       = AW'($urandom_range(0, 7));
            s.rd        = AW'($urandom_range(0, 7));
            s.ld_v      = ($urandom_range(0, 2) == 0);
            s.ld_rd     = AW'($urandom_range(0, 7));
            step(s);
        end
        step(idle());

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        #4;
        if (exp_q.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/exu_mul_issue_ctl.md
# exu_mul_issue_ctl

Decode-side issue controller for the three-stage multiplier pipeline. It turns a decoded multiply into a `mul_pkt_t`, including operand signedness, the low/high select and the load-result bypass selects. It keeps a shadow pipeline of in-flight multiply destinations in E1/E2/E3 and stalls decode on read-after-write hazards the multiplier cannot yet satisfy. It also drives the E3 writeback request for the register file.

## Interface
- `REG_AW`, default 5: register address width.
- `clk` input 1: core clock.
- `rst_l` input 1: reset, asynchronous, active-low.
- `freeze` input 1: pipeline freeze; all shadow state holds.
- `flush` input 1: kill all multiplies in E1/E2; E3 is already committing.
- `dec_valid` input 1: a decode-stage instruction is present.
- `dec_mul` input 1: that instruction is a multiply.
- `dec_mul_op` input 2: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU.
- `dec_rs1_en`, `dec_rs2_en` input 1 each: source reads are used.
- `dec_rs1_addr`, `dec_rs2_addr`, `dec_rd_addr` input REG_AW each: register addresses.
- `lsu_ld_valid_dc2` input 1: a load with a writeback is in DC2.
- `lsu_ld_rd_dc2` input REG_AW: that load's destination.
- `mp` output `mul_pkt_t`: packet to the multiplier. Fields: valid, rs1_sign, rs2_sign, low, load_mul_rs1_bypass_e1, load_mul_rs2_bypass_e1.
- `mul_stall` output 1: hold decode this cycle.
- `mul_wen_e3` output 1: multiply result write enable; `mul_rd_e3` output REG_AW: its destination.
- `mul_byp_rs1_e3`, `mul_byp_rs2_e3` output 1 each: the decode source equals the E3 destination, so the consumer takes the multiplier output by bypass.
- `mul_busy` output 1: any shadow stage valid.

## Operation
- **Decode to packet**
  - `rs1_sign` = op∈{1,2}.
  - `rs2_sign` = op==1.
  - `low` = op==0.
  - `mp.valid` = `dec_valid & dec_mul & ~mul_stall & ~freeze & ~flush`.
  - All `mp` fields are 0 when `mp.valid` is 0.
- **Load bypass**
  - `load_mul_rs1_bypass_e1` = `mp.valid & dec_rs1_en & lsu_ld_valid_dc2 & (dec_rs1_addr==lsu_ld_rd_dc2) & (dec_rs1_addr!=0)`.
  - `load_mul_rs2_bypass_e1` follows the same rule on rs2.
- **Shadow pipeline**: stages E1, E2, E3, each holding `{v, rd}`.
  - An issue loads E1 with `v=1` and `rd=dec_rd_addr`, except that `v=0` when rd==0.
  - Each non-frozen cycle advances E1→E2→E3; E3 drops out.
- **Hazard**
  - `mul_stall` = `dec_valid` & (rs1 or rs2 enabled, nonzero, and equal to a valid E1 or E2 rd).
  - Sources are evaluated against the current (pre-advance) E1/E2 contents.
  - A match against E3 does not stall; it raises the matching `mul_byp_*_e3` instead.
  - If both E2 and E3 match the same address, the stall wins; the E3 bypass flag is still reported.
- **Writeback**
  - `mul_wen_e3` = E3.v & ~freeze.
  - `mul_rd_e3` = E3.rd.
- **Flush**
  - Clears E1.v and E2.v at the clock edge.
  - E3 advances normally.
  - Suppresses issue in the same cycle.
- **Freeze**
  - No stage updates and no issue.
  - `mul_stall` still evaluates, so decode sees a consistent stall.
- **Simultaneous freeze and flush**: the flush takes effect; the E1/E2 valids clear and E3 holds.

## Timing
- Multiply issued in cycle N: E1 at N+1, E2 at N+2, E3 at N+3.
- At N+3, `mul_wen_e3`=1 and `mul_rd_e3`=rd; this matches multiplier `out` timing.
- Each frozen cycle delays every stage by one.
- `mp`, `mul_stall` and the bypass flags are combinational from decode and shadow state; there is no added latency.
- A dependent instruction decoded at N+1 or N+2 stalls; at N+3 it proceeds with E3 bypass.
- Back-to-back independent multiplies issue every cycle.
- **Reset**: all shadow `v`=0 and `rd`=0. Consequently `mul_busy`=0, `mul_wen_e3`=0, `mul_stall`=0, and `mp`=0 (with `dec_valid` low).
- Reset asserted mid-operation discards all in-flight entries with no writeback.

## Structure
- Shared `swerv_types` package:
  - already holds `mul_pkt_t`;
  - add the `mul_op` encoding constants MUL/MULH/MULHSU/MULHU.
- One sub-module, `exu_mul_shadow_stage`:
  - contents: `{v, rd}` register with hold, clear and load inputs;
  - compare ports giving match flags for rs1 and rs2;
  - instantiated three times.

## Test plan
- **Decode fields**: MULHSU with rd=5 issued, no hazards. Expect `mp`={valid=1, rs1_sign=1, rs2_sign=0, low=0, byp=0,0}; `mul_wen_e3`=1 with `mul_rd_e3`=5 exactly three cycles later.
- **RAW stall**: MUL rd=7, then ADD rs1=7 the next cycle. Expect `mul_stall`=1 for two cycles, then `mul_byp_rs1_e3`=1 and no stall.
- **Load bypass**: load rd=9 in DC2 while MUL rs2=9 is in decode. Expect `load_mul_rs2_bypass_e1`=1 and rs1 bypass 0. With rd=0 and rs2=0, expect the bypass to stay 0.
- **x0 handling**: MUL rd=0, then a consumer with rs1=0. Expect no stall and `mul_wen_e3`=0 at N+3.
- **Flush**: three back-to-back MULs (rd=1, 2, 3); flush when rd=3 is in E1 and rd=2 is in E2. Expect E3 writeback of rd=1 only, `mul_busy`=0 the cycle after.
- **Freeze and reset**: freeze for 2 cycles with MUL rd=4 in E2. Expect writeback delayed to N+5. Assert `rst_l` low mid-pipeline: all outputs are 0 immediately and no writeback occurs.
